// File: rtl/multdiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   - op encodings presented on the op port
//   - FSM state encoding
//   - step-counter width helper
package multdiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_DIV   = 2'b01;
  localparam logic [1:0] OP_MULTU = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CALC = 3'd1,
    S_FIX  = 3'd2,
    S_DONE = 3'd3,
    S_DZ   = 3'd4
  } stateT;

  // Width of a counter able to hold 0..width.
  function automatic int cntWidth(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/multdiv_step.sv
// One combinational iteration of the multiply/divide loop.
// The accumulator is {accHi, accLo}:
//   multiply: accHi = partial product high half, accLo = remaining multiplier bits
//             (low product bits shift in from the top as they are finalised)
//   divide:   accHi = partial remainder, accLo = dividend bits shifting out the
//             top while quotient bits shift in at the bottom
// Ports:
//   isDiv   in  1      selects trial-subtract (1) or shift-add (0)
//   accHi   in  WIDTH  current high accumulator half
//   accLo   in  WIDTH  current low accumulator half
//   opnd    in  WIDTH  multiplicand magnitude / divisor magnitude
//   stepHi  out WIDTH  next high accumulator half
//   stepLo  out WIDTH  next low accumulator half
import multdiv_pkg::*;

module multdiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             isDiv,
  input  logic [WIDTH-1:0] accHi,
  input  logic [WIDTH-1:0] accLo,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] stepHi,
  output logic [WIDTH-1:0] stepLo
);

  logic [WIDTH:0] addSum;
  logic [WIDTH:0] addSel;
  logic [WIDTH:0] remShift;
  logic [WIDTH:0] trial;

  always_comb begin
    addSum   = {1'b0, accHi} + {1'b0, opnd};
    addSel   = accLo[0] ? addSum : {1'b0, accHi};
    remShift = {accHi, accLo[WIDTH-1]};
    // remShift < 2*divisor, so a non-negative trial always fits in WIDTH bits
    trial    = remShift - {1'b0, opnd};
    stepHi   = '0;
    stepLo   = '0;
    if (isDiv) begin
      if (!trial[WIDTH]) begin
        stepHi = trial[WIDTH-1:0];
        stepLo = {accLo[WIDTH-2:0], 1'b1};
      end else begin
        stepHi = remShift[WIDTH-1:0];
        stepLo = {accLo[WIDTH-2:0], 1'b0};
      end
    end else begin
      // shift {carry, hi, lo} right by one; the carry keeps the add exact
      stepHi = addSel[WIDTH:1];
      stepLo = {addSel[0], accLo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit feeding the CPU HI/LO registers.
// Fixed latency: start accepted in cycle 0, done in cycle WIDTH+3
// (WIDTH CALC cycles plus two FIX cycles); divide by zero finishes in cycle 1.
// Optional build macro: MULTDIV_UNSIGNED_EN enables the MULTU/DIVU paths;
// without it op[1] is ignored and every operation is signed.
// Ports:
//   clock     in  1      system clock, rising edge
//   reset     in  1      synchronous, active-high
//   start     in  1      request strobe, sampled only in IDLE
//   op        in  2      00 MULT, 01 DIV, 10 MULTU, 11 DIVU
//   a         in  WIDTH  multiplicand / dividend
//   b         in  WIDTH  multiplier / divisor
//   busy      out 1      high in CALC and FIX
//   done      out 1      one-cycle completion pulse
//   div_zero  out 1      one-cycle pulse with done on divide by zero
//   hi        out WIDTH  product high half / remainder
//   lo        out WIDTH  product low half / quotient
import multdiv_pkg::*;

module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = cntWidth(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  stateT state, nextState;
  logic [CW-1:0] cnt;
  logic          fixPhase;

  logic             reqDiv;
  logic             reqSigned;
  logic             aNeg, bNeg;
  logic [WIDTH-1:0] magA, magB;

  logic             isDivR;
  logic             prodNeg, quoNeg, remNeg;
  logic [WIDTH-1:0] accHi, accLo, opnd;
  logic [WIDTH-1:0] stepHi, stepLo;

  // Request decode and operand magnitudes, evaluated in IDLE.
  always_comb begin
    reqDiv = (op == OP_DIV) || (op == OP_DIVU);
`ifdef MULTDIV_UNSIGNED_EN
    reqSigned = !((op == OP_MULTU) || (op == OP_DIVU));
`else
    reqSigned = 1'b1;
`endif
    aNeg = reqSigned && a[WIDTH-1];
    bNeg = reqSigned && b[WIDTH-1];
    // the most-negative value stays as its own magnitude, which is correct unsigned
    magA = aNeg ? (~a + 1'b1) : a;
    magB = bNeg ? (~b + 1'b1) : b;
  end

  always_comb begin
    nextState = state;
    busy      = 1'b0;
    done      = 1'b0;
    div_zero  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) nextState = (reqDiv && (b == '0)) ? S_DZ : S_CALC;
      end
      S_CALC: begin
        busy = 1'b1;
        if (cnt == LAST_STEP) nextState = S_FIX;
      end
      S_FIX: begin
        busy = 1'b1;
        if (fixPhase) nextState = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        nextState = S_IDLE;
      end
      S_DZ: begin
        done      = 1'b1;
        div_zero  = 1'b1;
        nextState = S_IDLE;
      end
      default: nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      fixPhase <= 1'b0;
    end else begin
      state <= nextState;
      case (state)
        S_IDLE: begin
          cnt      <= '0;
          fixPhase <= 1'b0;
        end
        S_CALC:  cnt      <= cnt + 1'b1;
        S_FIX:   fixPhase <= 1'b1;
        default: fixPhase <= 1'b0;
      endcase
    end
  end

  multdiv_step #(.WIDTH(WIDTH)) uStep (
    .isDiv  (isDivR),
    .accHi  (accHi),
    .accLo  (accLo),
    .opnd   (opnd),
    .stepHi (stepHi),
    .stepLo (stepLo)
  );

  // Datapath: load in IDLE, iterate in CALC, sign-correct in the first FIX cycle.
  always_ff @(posedge clock) begin
    case (state)
      S_IDLE: begin
        if (start) begin
          isDivR  <= reqDiv;
          prodNeg <= aNeg ^ bNeg;
          quoNeg  <= aNeg ^ bNeg;
          remNeg  <= aNeg;
          accHi   <= '0;
          accLo   <= reqDiv ? magA : magB;
          opnd    <= reqDiv ? magB : magA;
        end
      end
      S_CALC: begin
        accHi <= stepHi;
        accLo <= stepLo;
      end
      S_FIX: begin
        if (!fixPhase) begin
          if (isDivR) begin
            if (quoNeg) accLo <= ~accLo + 1'b1;
            if (remNeg) accHi <= ~accHi + 1'b1;
          end else if (prodNeg) begin
            {accHi, accLo} <= ~{accHi, accLo} + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Result registers change only when an operation completes normally.
  always_ff @(posedge clock) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if ((state == S_FIX) && fixPhase) begin
      hi <= accHi;
      lo <= accLo;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed testbench for mult_div_unit (WIDTH=32). Expected values are hand-computed.
// Builds with or without MULTDIV_UNSIGNED_EN; expectations follow the macro.
module tb_mult_div_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request (start in cycle 0), scramble a/b afterwards, wait for done.
  task automatic runOp(input string tag, input logic [1:0] o, input logic [31:0] av,
                       input logic [31:0] bv, input int expLat,
                       input logic [31:0] expHi, input logic [31:0] expLo,
                       input logic expDz);
    int n;
    @(negedge clock);
    op = o; a = av; b = bv; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    n = 1;
    check($sformatf("%s_busy1", tag), 64'(busy), 64'(expLat > 1));
    while (!done && n < 80) begin
      @(posedge clock); #1;
      n++;
    end
    check($sformatf("%s_latency", tag), 64'(n), 64'(expLat));
    check($sformatf("%s_hi", tag), 64'(hi), 64'(expHi));
    check($sformatf("%s_lo", tag), 64'(lo), 64'(expLo));
    check($sformatf("%s_divzero", tag), 64'(div_zero), 64'(expDz));
    @(posedge clock); #1;
    check($sformatf("%s_donepulse", tag), 64'(done), 64'd0);
  endtask

  initial begin
    int n;
    int doneCnt;
    reset = 1'b1; start = 1'b1; op = 2'b00; a = 32'd9; b = 32'd9;

    // reset wins over start
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0; start = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_divzero", 64'(div_zero), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);

    runOp("mult_7xm3", 2'b00, 32'd7, 32'hFFFFFFFD, 35, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    runOp("mult_big", 2'b00, 32'h12345678, 32'h10, 35, 32'h00000001, 32'h23456780, 1'b0);
    runOp("div_setup", 2'b01, 32'h2211, 32'h100, 35, 32'h11, 32'h22, 1'b0);
    runOp("div_zero", 2'b01, 32'd5, 32'd0, 1, 32'h11, 32'h22, 1'b1);
    runOp("div_m7_2", 2'b01, 32'hFFFFFFF9, 32'd2, 35, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
`ifdef MULTDIV_UNSIGNED_EN
    runOp("multu_max", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 35, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    runOp("divu_max", 2'b11, 32'hFFFFFFFF, 32'd2, 35, 32'h00000001, 32'h7FFFFFFF, 1'b0);
`else
    runOp("multu_max", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 35, 32'h00000000, 32'h00000001, 1'b0);
    runOp("divu_max", 2'b11, 32'hFFFFFFFF, 32'd2, 35, 32'hFFFFFFFF, 32'h00000000, 1'b0);
`endif
    runOp("div_minneg", 2'b01, 32'h80000000, 32'hFFFFFFFF, 35, 32'h00000000, 32'h80000000, 1'b0);

    // start while busy is ignored: MULT 3*5, then a DIV-by-zero request at cycle 15
    @(negedge clock);
    op = 2'b00; a = 32'd3; b = 32'd5; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (14) begin
      @(posedge clock); #1;
    end
    check("ign_busy15", 64'(busy), 64'd1);
    op = 2'b01; a = 32'd1; b = 32'd0; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    n = 16;
    while (!done && n < 80) begin
      @(posedge clock); #1;
      n++;
    end
    check("ign_latency", 64'(n), 64'd35);
    check("ign_hi", 64'(hi), 64'd0);
    check("ign_lo", 64'(lo), 64'd15);
    check("ign_divzero", 64'(div_zero), 64'd0);
    doneCnt = 0;
    repeat (5) begin
      @(posedge clock); #1;
      if (done) doneCnt++;
    end
    check("ign_nodone", 64'(doneCnt), 64'd0);

    // reset at cycle 10 aborts a MULT
    @(negedge clock);
    op = 2'b00; a = 32'd100; b = 32'd200; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clock); #1;
    end
    check("abort_busy10", 64'(busy), 64'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    doneCnt = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done) doneCnt++;
    end
    check("abort_nodone", 64'(doneCnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
